dc_top: RTL and testbench

- Chain of delay-commutator stages reordering a two-lane streaming complex FFT datapath (MDC, radix-2).
- Lane x0 carries samples i, lane x1 carries samples i+N/2.
- Output pairs are adjacent samples (0,1),(2,3),…,(N-2,N-1).
- Sits between butterfly stages / at the FFT input-output reorder point.

---
 rtl/dc_top.sv | 132 +++++++++++++
 tb/tb_dc_top.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dc_top.sv
// MDC radix-2 delay-commutator chain: reorders lanes (i, i+N/2) into adjacent pairs (2j, 2j+1).
// Optional macro DC_OUT_REG_EN adds one output register on y0, y1 and dc_chain_out_valid.
module dc_top #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] x0,
    input  logic [2*DATA_WIDTH-1:0] x1,
    output logic [2*DATA_WIDTH-1:0] y0,
    output logic [2*DATA_WIDTH-1:0] y1,
    output logic                    dc_chain_out_valid
);
    localparam int NUM_COMMUTATORS = $clog2(N) - 1;

    // Port vectors carry {r, i}; r occupies the upper half.
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] r;
        logic signed [DATA_WIDTH-1:0] i;
    } complex_product_t;

    complex_product_t x0_dc [NUM_COMMUTATORS-1];
    complex_product_t x1_dc [NUM_COMMUTATORS-1];
    logic             dc_out_valid [NUM_COMMUTATORS-1];

    complex_product_t y0_int;
    complex_product_t y1_int;
    logic             valid_int;

    generate
        for (genvar gi = 0; gi < NUM_COMMUTATORS; gi++) begin : g_stage
            localparam int D  = N / (4 << gi);
            localparam int CW = $clog2(D) + 1;

            complex_product_t a;
            complex_product_t b;
            logic             in_valid;
            complex_product_t lb_reg [D];
            complex_product_t up_reg [D];
            logic [CW-1:0]    cnt_reg;
            logic             out_valid_reg;
            logic             sel;
            complex_product_t p0;
            complex_product_t p1;
            complex_product_t out_a;
            complex_product_t out_b;

            if (gi == 0) begin : g_in_first
                assign a        = x0;
                assign b        = x1;
                assign in_valid = 1'b1;
            end else begin : g_in_chain
                assign a        = x0_dc[gi-1];
                assign b        = x1_dc[gi-1];
                assign in_valid = dc_out_valid[gi-1];
            end

            // cnt wraps every 2D cycles, so its top bit is (cnt / D) mod 2.
            assign sel = cnt_reg[CW-1];

            always_comb begin
                p0 = sel ? lb_reg[D-1] : a;
                p1 = sel ? a : lb_reg[D-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < D; j++) begin
                        lb_reg[j] <= '0;
                        up_reg[j] <= '0;
                    end
                    cnt_reg       <= '0;
                    out_valid_reg <= 1'b0;
                end else begin
                    lb_reg[0] <= b;
                    up_reg[0] <= p0;
                    for (int j = 1; j < D; j++) begin
                        lb_reg[j] <= lb_reg[j-1];
                        up_reg[j] <= up_reg[j-1];
                    end
                    if (in_valid) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(D - 1)) begin
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
            end

            assign out_a = out_valid_reg ? up_reg[D-1] : '0;
            assign out_b = out_valid_reg ? p1 : '0;

            if (gi == NUM_COMMUTATORS - 1) begin : g_out_last
                assign y0_int    = out_a;
                assign y1_int    = out_b;
                assign valid_int = out_valid_reg;
            end else begin : g_out_chain
                assign x0_dc[gi]        = out_a;
                assign x1_dc[gi]        = out_b;
                assign dc_out_valid[gi] = out_valid_reg;
            end
        end
    endgenerate

`ifdef DC_OUT_REG_EN
    complex_product_t y0_reg;
    complex_product_t y1_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            y0_reg    <= '0;
            y1_reg    <= '0;
            valid_reg <= 1'b0;
        end else begin
            y0_reg    <= y0_int;
            y1_reg    <= y1_int;
            valid_reg <= valid_int;
        end
    end

    assign y0                 = y0_reg;
    assign y1                 = y1_reg;
    assign dc_chain_out_valid = valid_reg;
`else
    assign y0                 = y0_int;
    assign y1                 = y1_int;
    assign dc_chain_out_valid = valid_int;
`endif

endmodule

// File: tb/tb_dc_top.sv
// Directed bench for dc_top at N=16: ramp reorder, complex fields, mid-stream reset.
// Expected latency follows DC_OUT_REG_EN.
module tb_dc_top;
    localparam int DW = 32;
    localparam int N  = 16;
`ifdef DC_OUT_REG_EN
    localparam int LAT = N / 2;
`else
    localparam int LAT = N / 2 - 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   x0 = '0;
    logic [63:0]   x1 = '0;
    logic [63:0]   y0;
    logic [63:0]   y1;
    logic          dc_chain_out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dc_top #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .x0                 (x0),
        .x1                 (x1),
        .y0                 (y0),
        .y1                 (y1),
        .dc_chain_out_valid (dc_chain_out_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] val(input int r, input bit use_im);
        logic [31:0] rr;
        logic [31:0] ii;
        rr = 32'(r);
        ii = use_im ? 32'(r + 100) : 32'd0;
        return {rr, ii};
    endfunction

    // Drives ramp x0.r=0..7, x1.r=8..15 then zeros; starts in the first post-reset cycle.
    task automatic run_ramp(input bit use_im, input string name);
        logic [63:0] e0, e1, e_s0a, e_s0b, e_s1a, e_s1b;
        for (int t = 0; t < LAT + 12; t++) begin
            if (t < 8) begin
                x0 = val(t, use_im);
                x1 = val(t + 8, use_im);
            end else begin
                x0 = '0;
                x1 = '0;
            end
            @(negedge clk);
            e0 = '0; e1 = '0; e_s0a = '0; e_s0b = '0; e_s1a = '0; e_s1b = '0;
            if (t >= 4 && t < 12) begin
                int m = t - 4;
                e_s0a = (m < 4) ? val(m, use_im)     : val(m + 4, use_im);
                e_s0b = (m < 4) ? val(m + 4, use_im) : val(m + 8, use_im);
            end
            if (t >= 6 && t < 14) begin
                int m = t - 6;
                int u = 4 * (m / 2) + (m % 2);
                e_s1a = val(u, use_im);
                e_s1b = val(u + 2, use_im);
            end
            if (t >= LAT && t < LAT + 8) begin
                e0 = val(2 * (t - LAT), use_im);
                e1 = val(2 * (t - LAT) + 1, use_im);
            end
            check($sformatf("%s.v0[%0d]", name, t), 64'(dut.dc_out_valid[0]), 64'(t >= 4));
            check($sformatf("%s.v1[%0d]", name, t), 64'(dut.dc_out_valid[1]), 64'(t >= 6));
            check($sformatf("%s.s0a[%0d]", name, t), dut.x0_dc[0], e_s0a);
            check($sformatf("%s.s0b[%0d]", name, t), dut.x1_dc[0], e_s0b);
            check($sformatf("%s.s1a[%0d]", name, t), dut.x0_dc[1], e_s1a);
            check($sformatf("%s.s1b[%0d]", name, t), dut.x1_dc[1], e_s1b);
            check($sformatf("%s.valid[%0d]", name, t), 64'(dc_chain_out_valid), 64'(t >= LAT));
            check($sformatf("%s.y0[%0d]", name, t), y0, e0);
            check($sformatf("%s.y1[%0d]", name, t), y1, e1);
            $display("%s t=%0d valid=%0b y0.r=%0d y0.i=%0d y1.r=%0d y1.i=%0d", name, t,
                     dc_chain_out_valid, $signed(y0[63:32]), $signed(y0[31:0]),
                     $signed(y1[63:32]), $signed(y1[31:0]));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.y0", y0, 64'd0);
        check("rst.y1", y1, 64'd0);
        check("rst.valid", 64'(dc_chain_out_valid), 64'd0);
        check("rst.v0", 64'(dut.dc_out_valid[0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_ramp(1'b0, "ramp");

        pulse_reset();
        run_ramp(1'b1, "cplx");

        // Partial ramp, then reset lands in cycle 5 and the ramp restarts.
        pulse_reset();
        for (int t = 0; t < 5; t++) begin
            x0 = val(t, 1'b0);
            x1 = val(t + 8, 1'b0);
            @(posedge clk);
            #1;
        end
        x0 = val(5, 1'b0);
        x1 = val(13, 1'b0);
        pulse_reset();
        run_ramp(1'b0, "midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
